// File: rtl/lamp_pkg.sv
// ============================================================================
//  Module      : lamp_pkg
//  Description : Shared constants, state encodings and size helpers for the
//                frame loader and its unpacker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lamp_pkg;

    localparam logic [7:0] c_sync           = 8'hA5;
    localparam int         c_chan_per_board = 32;

    // Parser states
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_time_hi = 3'd1;
    localparam logic [2:0] c_st_time_lo = 3'd2;
    localparam logic [2:0] c_st_payload = 3'd3;
    localparam logic [2:0] c_st_check   = 3'd4;

    // Triplet phases of the 12-bit unpacker
    localparam logic [1:0] c_ph_b0 = 2'd0;
    localparam logic [1:0] c_ph_b1 = 2'd1;
    localparam logic [1:0] c_ph_b2 = 2'd2;

    function automatic int f_channels(input int ledboards);
        return ledboards * c_chan_per_board;
    endfunction

    function automatic int f_addr_w(input int ledboards);
        return $clog2(f_channels(ledboards));
    endfunction

    function automatic int f_time_w(input int max_time);
        return $clog2(max_time);
    endfunction

    function automatic int f_payload(input int ledboards);
        return f_channels(ledboards) * 3 / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/unpack12.sv
// ============================================================================
//  Module      : unpack12
//  Description : Splits byte triplets into two 12-bit channel values; the
//                write decision and data are combinational on the byte strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unpack12
    import lamp_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_valid,
    output logic        o_odd,
    output logic [11:0] o_data
);

    logic [1:0] r_phase;
    logic [7:0] r_hold;

    assign o_valid = i_valid && (r_phase != c_ph_b0);
    assign o_odd   = (r_phase == c_ph_b2);
    // Even channel: held b0 + upper nibble of b1; odd: held low nibble of b1 + b2
    assign o_data  = o_odd ? {r_hold[3:0], i_data} : {r_hold, i_data[7:4]};

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_phase <= c_ph_b0;
            r_hold  <= 8'h00;
        end else if (i_valid) begin
            case (r_phase)
                c_ph_b0: begin
                    r_hold  <= i_data;
                    r_phase <= c_ph_b1;
                end
                c_ph_b1: begin
                    r_hold  <= {4'h0, i_data[3:0]};
                    r_phase <= c_ph_b2;
                end
                default: begin
                    r_phase <= c_ph_b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_loader.sv
// ============================================================================
//  Module      : frame_loader
//  Description : Byte-stream packet parser feeding the framebuffer with 12-bit
//                channel writes and issuing a commit with the transition time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_loader
    import lamp_pkg::*;
#(
    parameter int C_LEDBOARDS = 30,
    parameter int C_BPC       = 12,
    parameter int C_MAX_TIME  = 480,
    parameter int C_TIMEOUT   = 4096
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [7:0]                         i_data,
    input  logic                               i_valid,
    output logic                               o_wen,
    output logic [f_addr_w(C_LEDBOARDS)-1:0]   o_waddr,
    output logic [C_BPC-1:0]                   o_wdata,
    output logic [f_time_w(C_MAX_TIME)-1:0]    o_time,
    output logic                               o_commit,
    output logic                               o_err,
    output logic                               o_busy
);

    localparam int c_addr_w  = f_addr_w(C_LEDBOARDS);
    localparam int c_time_w  = f_time_w(C_MAX_TIME);
    localparam int c_payload = f_payload(C_LEDBOARDS);
    localparam int c_cnt_w   = $clog2(c_payload);
    localparam int c_tmo_w   = $clog2(C_TIMEOUT + 1);

    generate
        if (C_BPC != 12) begin : g_bpc_check
            $error("frame_loader: channel packing is defined for 12 bits only");
        end
    endgenerate

    logic [2:0]          r_state;
    logic [7:0]          r_sum;
    logic [15:0]         r_time16;
    logic [c_cnt_w-1:0]  r_bcnt;
    logic [c_tmo_w-1:0]  r_idle;
    logic [c_addr_w-2:0] r_pair;

    logic [7:0]  w_sum_next;
    logic        w_time_ok;
    logic        w_timeout;
    logic        w_pay_valid;
    logic        w_start_pay;
    logic        w_emit;
    logic        w_odd;
    logic [11:0] w_data;

    assign w_sum_next  = r_sum + i_data;
    assign w_time_ok   = (r_time16 <= 16'(C_MAX_TIME));
    // A byte in the expiry cycle keeps the packet alive
    assign w_timeout   = (r_state != c_st_idle) && !i_valid &&
                         (r_idle == c_tmo_w'(C_TIMEOUT - 1));
    assign w_pay_valid = i_valid && (r_state == c_st_payload);
    assign w_start_pay = i_valid && (r_state == c_st_time_lo);
    assign o_busy      = (r_state != c_st_idle);

    unpack12 u_unpack (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_start_pay),
        .i_valid (w_pay_valid),
        .i_data  (i_data),
        .o_valid (w_emit),
        .o_odd   (w_odd),
        .o_data  (w_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= c_st_idle;
            r_sum    <= 8'h00;
            r_time16 <= 16'h0000;
            r_bcnt   <= '0;
            r_idle   <= '0;
            r_pair   <= '0;
            o_wen    <= 1'b0;
            o_waddr  <= '0;
            o_wdata  <= '0;
            o_time   <= '0;
            o_commit <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_wen    <= 1'b0;
            o_commit <= 1'b0;
            o_err    <= 1'b0;

            if (w_emit) begin
                o_wen   <= 1'b1;
                o_waddr <= {r_pair, w_odd};
                o_wdata <= w_data;
                if (w_odd) begin
                    r_pair <= r_pair + (c_addr_w-1)'(1);
                end
            end

            if ((r_state == c_st_idle) || i_valid) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + c_tmo_w'(1);
            end

            case (r_state)
                c_st_idle: begin
                    r_sum <= 8'h00;
                    if (i_valid && (i_data == c_sync)) begin
                        r_state <= c_st_time_hi;
                    end
                end
                c_st_time_hi: begin
                    if (i_valid) begin
                        r_time16[15:8] <= i_data;
                        r_sum          <= w_sum_next;
                        r_state        <= c_st_time_lo;
                    end
                end
                c_st_time_lo: begin
                    if (i_valid) begin
                        r_time16[7:0] <= i_data;
                        r_sum         <= w_sum_next;
                        r_bcnt        <= '0;
                        r_pair        <= '0;
                        r_state       <= c_st_payload;
                    end
                end
                c_st_payload: begin
                    if (i_valid) begin
                        r_sum <= w_sum_next;
                        if (r_bcnt == c_cnt_w'(c_payload - 1)) begin
                            r_state <= c_st_check;
                        end else begin
                            r_bcnt <= r_bcnt + c_cnt_w'(1);
                        end
                    end
                end
                c_st_check: begin
                    if (i_valid) begin
                        if ((w_sum_next == 8'h00) && w_time_ok) begin
                            o_commit <= 1'b1;
                            o_time   <= r_time16[c_time_w-1:0];
                        end else begin
                            o_err <= 1'b1;
                        end
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            if (w_timeout) begin
                o_err   <= 1'b1;
                r_state <= c_st_idle;
            end
        end
    end

endmodule

`default_nettype wire
